// File: rtl/mm2s_pixel_fifo.sv
// Asymmetric single-clock FIFO: wide multi-lane words in, one {eol, sof, pixel} lane out per read.
// Optional sticky overflow/underflow flags: define MM2S_PIXEL_FIFO_ERRFLAG_EN.
module mm2s_pixel_fifo #(
    parameter int unsigned C_PIXEL_WIDTH    = 8,
    parameter int unsigned C_ADATA_PIXELS   = 4,
    parameter int unsigned C_DEPTH          = 512,
    parameter int unsigned C_DATACOUNT_BITS = 12
) (
    input  logic                                          f2s_aclk,
    input  logic                                          resetn,
    input  logic                                          flush,
    input  logic                                          wr_en,
    input  logic [C_ADATA_PIXELS*(C_PIXEL_WIDTH+2)-1:0]   wr_data,
    output logic                                          full,
    output logic [C_DATACOUNT_BITS-1:0]                   wr_data_count,
    input  logic                                          rd_en,
    output logic [C_PIXEL_WIDTH+1:0]                      rd_data,
    output logic                                          empty,
    output logic                                          overflow,
    output logic                                          underflow
);

    localparam int unsigned LW  = C_PIXEL_WIDTH + 2;
    localparam int unsigned AW  = $clog2(C_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned LNW = $clog2(C_ADATA_PIXELS);

    localparam logic [LNW-1:0] LANE_TOP = LNW'(C_ADATA_PIXELS - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(C_DEPTH);

    typedef logic [C_ADATA_PIXELS-1:0][LW-1:0] word_t;

    word_t          mem [C_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [LNW-1:0] lane;
    logic           wr_acc;
    logic           rd_acc;
    logic           rd_free;

    // Accept decisions and next occupancy; status flags are registered from count_nxt.
    always_comb begin
        wr_acc    = wr_en & ~full & ~flush;
        rd_acc    = rd_en & ~empty & ~flush;
        rd_free   = rd_acc & (lane == '0);
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc & ~rd_free) begin
            count_nxt = count + CW'(1);
        end else if (rd_free & ~wr_acc) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage array; left unreset so it can map onto a RAM.
    always_ff @(posedge f2s_aclk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= word_t'(wr_data);
        end
    end

    // Pointers, lane walker, occupancy and registered outputs.
    always_ff @(posedge f2s_aclk) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            lane          <= LANE_TOP;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            wr_data_count <= '0;
            rd_data       <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                lane   <= LANE_TOP;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_acc) begin
                    rd_data <= mem[rd_ptr][lane];
                    if (rd_free) begin
                        rd_ptr <= rd_ptr + AW'(1);
                        lane   <= LANE_TOP;
                    end else begin
                        lane <= lane - LNW'(1);
                    end
                end
            end
            count         <= count_nxt;
            full          <= (count_nxt == CNT_FULL);
            empty         <= (count_nxt == '0);
            wr_data_count <= C_DATACOUNT_BITS'(count_nxt);
        end
    end

`ifdef MM2S_PIXEL_FIFO_ERRFLAG_EN
    // Sticky error flags; only reset clears them, flush leaves them alone.
    always_ff @(posedge f2s_aclk) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full) begin
                overflow <= 1'b1;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_mm2s_pixel_fifo.sv
// Scoreboard bench for mm2s_pixel_fifo: lanes queued on accepted writes, popped on accepted reads.
module tb_mm2s_pixel_fifo;

    localparam int unsigned PW    = 8;
    localparam int unsigned NL    = 4;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned DCB   = 12;
    localparam int unsigned LW    = PW + 2;
    localparam int unsigned WW    = NL * LW;

    logic          f2s_aclk = 1'b0;
    logic          resetn   = 1'b0;
    logic          flush    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [WW-1:0] wr_data  = '0;
    logic          full;
    logic [DCB-1:0] wr_data_count;
    logic          rd_en    = 1'b0;
    logic [LW-1:0] rd_data;
    logic          empty;
    logic          overflow;
    logic          underflow;

    mm2s_pixel_fifo #(
        .C_PIXEL_WIDTH(PW), .C_ADATA_PIXELS(NL), .C_DEPTH(DEPTH), .C_DATACOUNT_BITS(DCB)
    ) dut (
        .f2s_aclk(f2s_aclk), .resetn(resetn), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .wr_data_count(wr_data_count),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 f2s_aclk = ~f2s_aclk;

`ifdef MM2S_PIXEL_FIFO_ERRFLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [LW-1:0] sb [$];
    int            m_w    = 0;
    int            m_l    = NL - 1;
    logic [LW-1:0] m_rd   = '0;
    bit            m_ovf  = 1'b0;
    bit            m_unf  = 1'b0;
    int            n_wacc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output after the edge.
    task automatic step(input bit w, input logic [WW-1:0] wd, input bit r, input bit fl);
        bit wacc;
        bit racc;
        bit frees;
        wr_en = w; wr_data = wd; rd_en = r; flush = fl;
        wacc  = w && (m_w != DEPTH) && !fl;
        racc  = r && (m_w != 0) && !fl;
        frees = racc && (m_l == 0);
        if (ERR_EN && w && m_w == DEPTH) m_ovf = 1'b1;
        if (ERR_EN && r && m_w == 0)     m_unf = 1'b1;
        if (fl) begin
            sb.delete();
            m_w = 0;
            m_l = NL - 1;
        end else begin
            if (racc) begin
                m_rd = sb.pop_front();
                m_l  = (m_l == 0) ? NL - 1 : m_l - 1;
            end
            if (wacc) begin
                for (int k = NL - 1; k >= 0; k--) sb.push_back(wd[k*LW +: LW]);
                n_wacc++;
            end
            m_w = m_w + int'(wacc) - int'(frees);
        end
        @(posedge f2s_aclk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        chk("rd_data", 32'(rd_data), 32'(m_rd));
        chk("count", 32'(wr_data_count), 32'(m_w));
        chk("full", 32'(full), 32'(m_w == DEPTH));
        chk("empty", 32'(empty), 32'(m_w == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (m_w != 0 && guard < 4 * DEPTH * NL) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_done", 32'(empty), 32'(1));
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] v;
        for (int k = 0; k < NL; k++) v[k*LW +: LW] = LW'($urandom);
        return v;
    endfunction

    initial begin
        logic [WW-1:0] wd;
        logic [LW-1:0] last;
        int guard;

        resetn = 1'b0;
        repeat (3) @(posedge f2s_aclk);
        #1;
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_count", 32'(wr_data_count), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_underflow", 32'(underflow), 32'(0));
        resetn = 1'b1;

        // Lane order
        wd = {10'h111, 10'h022, 10'h033, 10'h244};
        step(1'b1, wd, 1'b0, 1'b0);
        chk("lo_count1", 32'(wr_data_count), 32'(1));
        step(1'b0, '0, 1'b1, 1'b0); chk("lo_lane3", 32'(rd_data), 32'h111);
        chk("lo_count_mid", 32'(wr_data_count), 32'(1));
        step(1'b0, '0, 1'b1, 1'b0); chk("lo_lane2", 32'(rd_data), 32'h022);
        step(1'b0, '0, 1'b1, 1'b0); chk("lo_lane1", 32'(rd_data), 32'h033);
        chk("lo_count_pre", 32'(wr_data_count), 32'(1));
        step(1'b0, '0, 1'b1, 1'b0); chk("lo_lane0", 32'(rd_data), 32'h244);
        chk("lo_empty", 32'(empty), 32'(1));
        chk("lo_count0", 32'(wr_data_count), 32'(0));

        // Underflow on empty
        step(1'b0, '0, 1'b1, 1'b0);
        chk("uf_hold", 32'(rd_data), 32'h244);
        chk("uf_flag", 32'(underflow), 32'(ERR_EN));

        // Fill to capacity, then overflow attempt
        for (int i = 0; i < DEPTH; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_count", 32'(wr_data_count), 32'(DEPTH));
        step(1'b1, rand_word(), 1'b0, 1'b0);
        chk("of_count", 32'(wr_data_count), 32'(DEPTH));
        chk("of_flag", 32'(overflow), 32'(ERR_EN));
        // Freeing read with a write in the same cycle while full: write still rejected
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rand_word(), 1'b1, 1'b0);
        chk("of_free_full", 32'(full), 32'(0));
        chk("of_free_count", 32'(wr_data_count), 32'(DEPTH - 1));
        drain();

        // Simultaneous write and freeing read
        for (int i = 0; i < 3; i++) step(1'b1, rand_word(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rand_word(), 1'b1, 1'b0);
        chk("sim_l0_count", 32'(wr_data_count), 32'(3));
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rand_word(), 1'b1, 1'b0);
        chk("sim_l2_count", 32'(wr_data_count), 32'(4));
        drain();

        // Wrap-around random stream
        n_wacc = 0;
        guard  = 0;
        while (n_wacc < 2000 && guard < 40000) begin
            step(($urandom % 4) == 0, rand_word(), ($urandom % 4) != 0, 1'b0);
            guard++;
        end
        chk("stream_done", 32'(n_wacc >= 2000), 32'(1));
        drain();

        // Flush mid-word
        step(1'b1, rand_word(), 1'b0, 1'b0);
        step(1'b1, rand_word(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        last = m_rd;
        step(1'b0, '0, 1'b0, 1'b1);
        chk("fl_empty", 32'(empty), 32'(1));
        chk("fl_count", 32'(wr_data_count), 32'(0));
        chk("fl_hold", 32'(rd_data), 32'(last));
        wd = {10'h3A5, 10'h15A, 10'h0F0, 10'h20F};
        step(1'b1, wd, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fl_lane3", 32'(rd_data), 32'h3A5);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
